// File: rtl/fp_classify_norm.sv
// Two-stage pipeline that classifies an IEEE-style float word (S1) and
// normalises num results to an explicit-leading-one mantissa (S2).
module fp_classify_norm #(
    parameter int EXP_W  = 5,
    parameter int MANT_W = 10,
    parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [EXP_W+MANT_W:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       is_num,
    output logic                       is_zero,
    output logic                       is_nan,
    output logic                       is_pinf,
    output logic                       is_ninf,
    output logic                       sign_out,
    output logic signed [EXP_W+1:0]    exp_out,
    output logic [MANT_W:0]            mant_out
);

    localparam int EW  = EXP_W + 2;
    localparam int MW  = MANT_W + 1;
    localparam int LZW = $clog2(MW + 1);

    // One-hot class, bit order {num, zero, nan, pinf, ninf}.
    localparam logic [4:0] CLS_NUM  = 5'b10000;
    localparam logic [4:0] CLS_ZERO = 5'b01000;
    localparam logic [4:0] CLS_NAN  = 5'b00100;
    localparam logic [4:0] CLS_PINF = 5'b00010;
    localparam logic [4:0] CLS_NINF = 5'b00001;

    logic                 run_q,      run_d;
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_sign_q,  s1_sign_d;
    logic [EXP_W-1:0]     s1_exp_q,   s1_exp_d;
    logic [MANT_W-1:0]    s1_mant_q,  s1_mant_d;
    logic                 s1_sub_q,   s1_sub_d;
    logic [4:0]           s1_cls_q,   s1_cls_d;
    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q,  s2_sign_d;
    logic signed [EW-1:0] s2_exp_q,   s2_exp_d;
    logic [MW-1:0]        s2_mant_q,  s2_mant_d;
    logic [4:0]           s2_cls_q,   s2_cls_d;

    logic                 in_sign;
    logic [EXP_W-1:0]     in_exp;
    logic [MANT_W-1:0]    in_mant;
    logic                 exp_ones;
    logic                 exp_zero;
    logic                 mant_zero;
    logic [4:0]           in_cls;

    logic                 s2_free;
    logic                 s1_adv;
    logic                 in_fire;
    logic                 out_fire;

    logic [MW-1:0]        sub_vec;
    logic [LZW-1:0]       lz;
    logic                 lz_found;
    logic signed [EW-1:0] norm_exp;
    logic [MW-1:0]        norm_mant;

    // Handshake: a word moves across a boundary only in a cycle where
    // enable=1, the producer's valid is high and the consumer's ready is
    // high. Ready never looks at in_valid; a stage accepts when empty or
    // when its current word leaves in the same cycle.
    assign s2_free  = ~s2_valid_q | out_ready;
    assign s1_adv   = enable & s1_valid_q & s2_free;
    assign in_ready = enable & run_q & (~s1_valid_q | s1_adv);
    assign in_fire  = in_valid & in_ready;
    assign out_fire = enable & s2_valid_q & out_ready;

    // Unpack and classify the incoming word.
    assign in_sign   = in_data[EXP_W+MANT_W];
    assign in_exp    = in_data[MANT_W +: EXP_W];
    assign in_mant   = in_data[MANT_W-1:0];
    assign exp_ones  = &in_exp;
    assign exp_zero  = ~|in_exp;
    assign mant_zero = ~|in_mant;

    always_comb begin
        in_cls = CLS_NUM;
        if (exp_ones) begin
            if (!mant_zero) begin
                in_cls = CLS_NAN;
            end else if (in_sign) begin
                in_cls = CLS_NINF;
            end else begin
                in_cls = CLS_PINF;
            end
        end else if (exp_zero && mant_zero) begin
            in_cls = CLS_ZERO;
        end
    end

    // Leading-zero count of {0, mant}; the forced zero MSB guarantees lz >= 1.
    assign sub_vec = {1'b0, s1_mant_q};

    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (sub_vec[i]) begin
                    lz_found = 1'b1;
                end else begin
                    lz = lz + LZW'(1);
                end
            end
        end
    end

    always_comb begin
        norm_exp  = '0;
        norm_mant = '0;
        if (s1_cls_q == CLS_NUM) begin
            if (s1_sub_q) begin
                norm_mant = sub_vec << lz;
                norm_exp  = EW'(1) - EW'(BIAS) - EW'(lz);
            end else begin
                norm_mant = {1'b1, s1_mant_q};
                norm_exp  = EW'(s1_exp_q) - EW'(BIAS);
            end
        end
    end

    always_comb begin
        run_d      = run_q;
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        s1_sub_d   = s1_sub_q;
        s1_cls_d   = s1_cls_q;
        s2_valid_d = s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_exp_d   = s2_exp_q;
        s2_mant_d  = s2_mant_q;
        s2_cls_d   = s2_cls_q;

        if (enable) begin
            run_d = 1'b1;
        end

        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_sign_d  = in_sign;
            s1_exp_d   = in_exp;
            s1_mant_d  = in_mant;
            s1_sub_d   = exp_zero;
            s1_cls_d   = in_cls;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_sign_d  = s1_sign_q;
            s2_exp_d   = norm_exp;
            s2_mant_d  = norm_mant;
            s2_cls_d   = s1_cls_q;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_sub_q   <= 1'b0;
            s1_cls_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_mant_q  <= '0;
            s2_cls_q   <= '0;
        end else begin
            run_q      <= run_d;
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s1_sub_q   <= s1_sub_d;
            s1_cls_q   <= s1_cls_d;
            s2_valid_q <= s2_valid_d;
            s2_sign_q  <= s2_sign_d;
            s2_exp_q   <= s2_exp_d;
            s2_mant_q  <= s2_mant_d;
            s2_cls_q   <= s2_cls_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign {is_num, is_zero, is_nan, is_pinf, is_ninf} = s2_cls_q;
    assign sign_out  = s2_sign_q;
    assign exp_out   = s2_exp_q;
    assign mant_out  = s2_mant_q;

endmodule

// File: tb/tb_fp_classify_norm.sv
// Bench for fp_classify_norm: directed vector table, backpressure, freeze
// and reset sequences, plus random traffic against a scoreboard model.
module tb_fp_classify_norm;

    localparam int EXP_W  = 5;
    localparam int MANT_W = 10;
    localparam int BIAS   = 15;
    localparam int DW     = 1 + EXP_W + MANT_W;
    localparam int EW     = EXP_W + 2;
    localparam int MW     = MANT_W + 1;
    localparam int RW     = 5 + 1 + EW + MW;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 is_num, is_zero, is_nan, is_pinf, is_ninf;
    logic                 sign_out;
    logic signed [EW-1:0] exp_out;
    logic [MW-1:0]        mant_out;
    logic [RW-1:0]        dut_res;

    typedef struct {
        logic [DW-1:0]        din;
        logic [4:0]           cls;
        logic                 sgn;
        logic signed [EW-1:0] e;
        logic [MW-1:0]        m;
    } vec_t;

    vec_t          tbl[14];
    logic [RW-1:0] exp_q[$];
    int            got_q[$];
    logic          log_en;
    logic          armed;
    int            n_vec;
    int            n_err;

    fp_classify_norm #(.EXP_W(EXP_W), .MANT_W(MANT_W), .BIAS(BIAS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .is_num(is_num), .is_zero(is_zero), .is_nan(is_nan),
        .is_pinf(is_pinf), .is_ninf(is_ninf),
        .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out)
    );

    assign dut_res = {is_num, is_zero, is_nan, is_pinf, is_ninf, sign_out, exp_out, mant_out};

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in_ready may rise from the first enabled rising edge after reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) armed <= 1'b0;
        else if (enable) armed <= 1'b1;
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference: class and normalised value straight from the float rules.
    function automatic logic [RW-1:0] ref_model(input logic [DW-1:0] w);
        int   ef   = int'(w[DW-2 -: EXP_W]);
        int   mf   = int'(w[MANT_W-1:0]);
        int   emax = (1 << EXP_W) - 1;
        int   one  = 1 << MANT_W;
        int   e    = 0;
        int   m    = 0;
        logic s    = w[DW-1];
        logic [4:0] cls;
        if (ef == emax && mf != 0)      cls = 5'b00100;
        else if (ef == emax)            cls = s ? 5'b00001 : 5'b00010;
        else if (ef == 0 && mf == 0)    cls = 5'b01000;
        else begin
            cls = 5'b10000;
            if (ef != 0) begin
                e = ef - BIAS;
                m = mf + one;
            end else begin
                e = 1 - BIAS;
                m = mf;
                while (m < one) begin
                    m = m * 2;
                    e = e - 1;
                end
            end
        end
        return {cls, s, EW'(e), MW'(m)};
    endfunction

    function automatic logic [DW-1:0] rand_word();
        int            k = $urandom_range(0, 3);
        logic [DW-1:0] w = DW'($urandom);
        case (k)
            1: w[DW-2 -: EXP_W] = '0;
            2: w[DW-2 -: EXP_W] = '1;
            3: w[MANT_W-1:0]    = '0;
            default: ;
        endcase
        return w;
    endfunction

    // Scoreboard: tracks words accepted but not yet delivered.
    task automatic monitor();
        logic [RW-1:0] req;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                check("in_ready", 32'(in_ready),
                      32'(armed && enable && (exp_q.size() < 2 || out_ready)));
                if (enable && out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 32'(out_valid), 32'(0));
                    end else begin
                        req = exp_q.pop_front();
                        check("scoreboard", 32'(dut_res), 32'(req));
                        if (log_en) got_q.push_back(int'(exp_out));
                    end
                end
                if (enable && in_valid && in_ready) exp_q.push_back(ref_model(in_data));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one word into an idle pipeline and check 2-cycle latency and fields.
    task automatic send_check(input vec_t v);
        int t = 0;
        in_data  = v.din;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("accept_timeout", 32'(in_ready), 32'(1));
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_c1", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("latency_c2", 32'(out_valid), 32'(1));
        check("vec_class", 32'({is_num, is_zero, is_nan, is_pinf, is_ninf}), 32'(v.cls));
        check("vec_sign", 32'(sign_out), 32'(v.sgn));
        check("vec_exp", 32'(exp_out), 32'(v.e));
        check("vec_mant", 32'(mant_out), 32'(v.m));
        tick();
    endtask

    initial begin
        logic [DW-1:0] stream[5];
        int            exps[5];
        int            idx;
        int            cyc;
        logic [RW:0]   snap;

        n_vec = 0; n_err = 0; log_en = 1'b0;
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

        tbl[0]  = '{16'h4400, 5'b10000, 1'b0,  7'sd2,   11'h400};
        tbl[1]  = '{16'h0001, 5'b10000, 1'b0, -7'sd24,  11'h400};
        tbl[2]  = '{16'h03FF, 5'b10000, 1'b0, -7'sd15,  11'h7FE};
        tbl[3]  = '{16'h7C00, 5'b00010, 1'b0,  7'sd0,   11'h000};
        tbl[4]  = '{16'hFC00, 5'b00001, 1'b1,  7'sd0,   11'h000};
        tbl[5]  = '{16'hFE00, 5'b00100, 1'b1,  7'sd0,   11'h000};
        tbl[6]  = '{16'h8000, 5'b01000, 1'b1,  7'sd0,   11'h000};
        tbl[7]  = '{16'h3C00, 5'b10000, 1'b0,  7'sd0,   11'h400};
        tbl[8]  = '{16'h7BFF, 5'b10000, 1'b0,  7'sd15,  11'h7FF};
        tbl[9]  = '{16'h0400, 5'b10000, 1'b0, -7'sd14,  11'h400};
        tbl[10] = '{16'h7C01, 5'b00100, 1'b0,  7'sd0,   11'h000};
        tbl[11] = '{16'h0000, 5'b01000, 1'b0,  7'sd0,   11'h000};
        tbl[12] = '{16'h0200, 5'b10000, 1'b0, -7'sd15,  11'h400};
        tbl[13] = '{16'h8001, 5'b10000, 1'b1, -7'sd24,  11'h400};

        fork
            monitor();
        join_none

        repeat (3) tick();
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_outputs", 32'(dut_res), 32'(0));
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();

        for (int i = 0; i < 14; i++) send_check(tbl[i]);

        // Backpressure stream with random consumer stalls.
        stream[0] = 16'h3C00; stream[1] = 16'h4000; stream[2] = 16'h4200;
        stream[3] = 16'h4400; stream[4] = 16'h4500;
        exps[0] = 0; exps[1] = 1; exps[2] = 1; exps[3] = 2; exps[4] = 2;
        got_q.delete();
        log_en = 1'b1;
        idx = 0;
        cyc = 0;
        while ((idx < 5 || got_q.size() < 5) && cyc < 300) begin
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (idx < 5);
            in_data   = (idx < 5) ? stream[idx] : '0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        log_en    = 1'b0;
        check("bp_count", 32'(got_q.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) check("bp_exp_order", 32'(got_q[i]), 32'(exps[i]));
        end

        // Freeze mid-stream.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h4100 + 16'(i);
            out_ready = (i != 2);
            tick();
        end
        enable = 1'b0;
        snap = {out_valid, dut_res};
        for (int i = 0; i < 3; i++) begin
            in_data   = rand_word();
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("freeze_outputs", 32'({out_valid, dut_res}), 32'(snap));
            check("freeze_in_ready", 32'(in_ready), 32'(0));
            tick();
        end
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("freeze_drain", 32'(exp_q.size()), 32'(0));

        // Random traffic against the reference model.
        for (int c = 0; c < 600; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rand_word();
            tick();
        end
        enable    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) tick();
        check("random_drain", 32'(exp_q.size()), 32'(0));

        // Reset with two words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h4400;
        tick();
        in_data   = 16'h4500;
        tick();
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(0));
        check("midrst_outputs", 32'(dut_res), 32'(0));
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_word", 32'(out_valid), 32'(0));
            tick();
        end
        send_check(tbl[2]);
        repeat (3) tick();
        check("final_drain", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
